// File: rtl/sha256_pkg.sv
// Shared types and sizing helpers for the SHA-256 host loader.
// Sizing follows SHA-256 padding: message bits L, plus the 0x80 marker and a 64-bit
// length field, rounded up to whole 512-bit blocks.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PAD,
        START,
        WAIT,
        RDREQ,
        RDWAIT,
        EMIT
    } state_t;

    localparam logic [31:0] PAD_MARKER = 32'h8000_0000;

    // Message length in bits for a message of n 32-bit words.
    function automatic int unsigned msg_bits(input int unsigned n);
        return 32 * n;
    endfunction

    // Number of 32-bit words after padding: 16 words per 512-bit block.
    function automatic int unsigned padded_words(input int unsigned n);
        return 16 * ((msg_bits(n) + 65 + 511) / 512);
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Combinational pad-word generator: the marker word right after the message,
// the low half of the bit length in the last word, zeros everywhere else.
// The high half of the length (word P-2) is always zero for supported sizes.
module sha256_pad_word
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20
) (
    input  logic [15:0] idx_i,
    output logic [31:0] word_o
);

    localparam int unsigned PADDED     = padded_words(NUM_OF_WORDS);
    localparam logic [15:0] MARKER_IDX = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LEN_IDX    = 16'(PADDED - 1);
    localparam logic [31:0] LEN_LO     = 32'(msg_bits(NUM_OF_WORDS));

    // Select the pad word for the requested index.
    always_comb begin
        word_o = '0;
        if (idx_i == MARKER_IDX) begin
            word_o = PAD_MARKER;
        end else if (idx_i == LEN_IDX) begin
            word_o = LEN_LO;
        end
    end

endmodule

// File: rtl/sha256_host_loader.sv
// Host-side front end for the memory-mapped SHA-256 hasher: streams the message and
// its padding into shared memory, kicks the hasher, waits for done (with a watchdog)
// and streams h0..h7 back out.
// Memory port outputs are registered, so every write lands one cycle after it is
// decided. The final pad write therefore lands during START; the start pulse and the
// hand-over of the memory port are registered as well so both take effect on the
// following cycle and that last write is never routed away from the memory.
module sha256_host_loader
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS   = 20,
    parameter logic [15:0] MSG_BASE       = 16'h0000,
    parameter logic [15:0] OUT_BASE       = 16'h0400,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        mem_own,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        eng_start,
    input  logic        eng_done,
    output logic [15:0] eng_message_addr,
    output logic [15:0] eng_output_addr,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned PADDED       = padded_words(NUM_OF_WORDS);
    localparam logic [15:0] NUM_WORDS16  = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LAST_MSG_IDX = 16'(NUM_OF_WORDS - 1);
    localparam logic [15:0] LAST_PAD_IDX = 16'(PADDED - 1);
    localparam logic [31:0] WDOG_LIMIT   = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] wdog_q, wdog_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] out_data_q, out_data_d;
    logic        eng_start_q, eng_start_d;
    logic        mem_own_q, mem_own_d;
    logic        timeout_err_q, timeout_err_d;
    logic [31:0] pad_word;
    logic        in_fire;
    logic        out_fire;

    sha256_pad_word #(
        .NUM_OF_WORDS(NUM_OF_WORDS)
    ) u_pad_word (
        .idx_i (count_q),
        .word_o(pad_word)
    );

    assign in_ready         = (state_q == IDLE) || ((state_q == LOAD) && (count_q < NUM_WORDS16));
    assign in_fire          = in_valid & in_ready;
    assign out_valid        = (state_q == EMIT);
    assign out_fire         = out_valid & out_ready;
    assign out_last         = out_valid & (idx_q == 3'd7);
    assign out_data         = out_data_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_write_data   = mem_wdata_q;
    assign mem_own          = mem_own_q;
    assign eng_start        = eng_start_q;
    assign eng_message_addr = MSG_BASE;
    assign eng_output_addr  = OUT_BASE;
    assign busy             = (state_q != IDLE);
    assign timeout_err      = timeout_err_q;

    // Next-state and registered-output decisions; the memory port only pulses we.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        idx_d         = idx_q;
        wdog_d        = wdog_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        out_data_d    = out_data_q;
        eng_start_d   = 1'b0;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            IDLE: begin
                if (in_fire) begin
                    mem_we_d      = 1'b1;
                    mem_addr_d    = MSG_BASE;
                    mem_wdata_d   = in_data;
                    count_d       = 16'd1;
                    timeout_err_d = 1'b0;
                    state_d       = (NUM_OF_WORDS == 1) ? PAD : LOAD;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = MSG_BASE + count_q;
                    mem_wdata_d = in_data;
                    count_d     = count_q + 16'd1;
                    if (count_q == LAST_MSG_IDX) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = MSG_BASE + count_q;
                mem_wdata_d = pad_word;
                count_d     = count_q + 16'd1;
                if (count_q == LAST_PAD_IDX) begin
                    state_d = START;
                end
            end
            START: begin
                eng_start_d = 1'b1;
                wdog_d      = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    idx_d      = 3'd0;
                    mem_addr_d = OUT_BASE;
                    state_d    = RDREQ;
                end else if (wdog_q == WDOG_LIMIT) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
            end
            RDREQ: begin
                state_d = RDWAIT;
            end
            RDWAIT: begin
                out_data_d = mem_read_data;
                state_d    = EMIT;
            end
            EMIT: begin
                if (out_fire) begin
                    if (idx_q == 3'd7) begin
                        state_d = IDLE;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        mem_addr_d = OUT_BASE + {13'd0, idx_q} + 16'd1;
                        state_d    = RDREQ;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_own_d = (state_d != WAIT);
    end

    // State and output registers; reset abandons any message in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            count_q       <= '0;
            idx_q         <= '0;
            wdog_q        <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            out_data_q    <= '0;
            eng_start_q   <= 1'b0;
            mem_own_q     <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            wdog_q        <= wdog_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            out_data_q    <= out_data_d;
            eng_start_q   <= eng_start_d;
            mem_own_q     <= mem_own_d;
            timeout_err_q <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_sha256_host_loader.sv
// Self-checking bench for sha256_host_loader: 20-word message with a 50-cycle
// watchdog, a behavioural shared memory, and standalone pad-word instances for
// the 13- and 14-word layouts.
module tb_sha256_host_loader;
    import sha256_pkg::*;

    localparam int unsigned NW  = 20;
    localparam int unsigned TMO = 50;

    typedef struct {
        int          n;
        logic [15:0] idx;
        logic [31:0] exp;
    } padVec_t;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wrVec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        mem_own;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        eng_start;
    logic        eng_done;
    logic [15:0] eng_message_addr;
    logic [15:0] eng_output_addr;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem [0:65535];
    logic        preloadReq;
    logic [31:0] preloadBase;

    logic [15:0] wrAddr[$];
    logic [31:0] wrData[$];
    int          wrCyc[$];
    int          startCyc[$];
    logic [31:0] outData[$];
    logic        outLast[$];
    int          outCyc[$];
    logic [31:0] stallExp[$];
    logic [31:0] stallAct[$];
    int          lostWrites = 0;
    logic        prevStall = 1'b0;
    logic [31:0] prevData = '0;

    logic [15:0] pwIdx;
    logic [31:0] pw13, pw14, pw20;

    padVec_t padVecs[10];
    wrVec_t  wrVecs[32];

    always #5 clk = ~clk;

    sha256_host_loader #(
        .NUM_OF_WORDS  (NW),
        .MSG_BASE      (16'h0000),
        .OUT_BASE      (16'h0400),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .mem_own         (mem_own),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_write_data  (mem_write_data),
        .mem_read_data   (mem_read_data),
        .eng_start       (eng_start),
        .eng_done        (eng_done),
        .eng_message_addr(eng_message_addr),
        .eng_output_addr (eng_output_addr),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    sha256_pad_word #(.NUM_OF_WORDS(13)) uPw13 (.idx_i(pwIdx), .word_o(pw13));
    sha256_pad_word #(.NUM_OF_WORDS(14)) uPw14 (.idx_i(pwIdx), .word_o(pw14));
    sha256_pad_word #(.NUM_OF_WORDS(20)) uPw20 (.idx_i(pwIdx), .word_o(pw20));

    // Cycle counter used to timestamp port activity.
    always @(posedge clk) cyc <= cyc + 1;

    // Shared memory: one-cycle read latency, writes only when the loader owns the port.
    always @(posedge clk) begin
        mem_read_data <= mem[mem_addr];
        if (mem_we && mem_own) mem[mem_addr] <= mem_write_data;
        if (preloadReq) begin
            for (int i = 0; i < 8; i++) mem[16'h0400 + 16'(i)] <= preloadBase + 32'(i);
        end
    end

    // Record writes, start pulses, output transfers and stalled output words mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            if (mem_own) begin
                wrAddr.push_back(mem_addr);
                wrData.push_back(mem_write_data);
                wrCyc.push_back(cyc);
            end else begin
                lostWrites = lostWrites + 1;
            end
        end
        if (eng_start) startCyc.push_back(cyc);
        if (out_valid && out_ready) begin
            outData.push_back(out_data);
            outLast.push_back(out_last);
            outCyc.push_back(cyc);
        end
        if (prevStall && out_valid) begin
            stallExp.push_back(prevData);
            stallAct.push_back(out_data);
        end
        prevStall = out_valid && !out_ready;
        prevData  = out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] base);
        preloadBase = base;
        preloadReq  = 1'b1;
        tick();
        preloadReq  = 1'b0;
    endtask

    // Stream words 0..NW-1 with in_valid held high; optionally poke eng_done mid-load.
    task automatic applyStimulus(input bit pokeDone);
        int   k = 0;
        int   g = 0;
        logic wasReady;
        in_valid = 1'b1;
        while (k < int'(NW) && g < 200) begin
            in_data  = 32'(k);
            eng_done = pokeDone && (k == 5);
            wasReady = in_ready;
            tick();
            if (wasReady) k++;
            g++;
        end
        in_valid = 1'b0;
        eng_done = 1'b0;
        checkOutput("msg_accepted", 32'(k), 32'(NW));
        checkOutput("msg_cycles", 32'(g), 32'(NW));
    endtask

    task automatic waitStart();
        int g = 0;
        while (eng_start !== 1'b1 && g < 200) begin
            tick();
            g++;
        end
        checkOutput("start_seen", {31'd0, eng_start}, 32'd1);
    endtask

    task automatic checkWrites(input int base);
        checkOutput("write_count", 32'(wrAddr.size() - base), 32'd32);
        if (wrAddr.size() >= base + 32) begin
            for (int i = 0; i < 32; i++) begin
                checkOutput($sformatf("wr_addr[%0d]", i), {16'd0, wrAddr[base + i]}, {16'd0, wrVecs[i].addr});
                checkOutput($sformatf("wr_data[%0d]", i), wrData[base + i], wrVecs[i].data);
            end
        end
    endtask

    task automatic drainOutput(input bit stall);
        int   g  = 0;
        int   ph = 0;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        while (busy && g < 200) begin
            if (!stall) begin
                out_ready = 1'b1;
            end else if (out_valid) begin
                out_ready = pat[ph % 4];
                ph++;
            end else begin
                out_ready = 1'b0;
            end
            tick();
            g++;
        end
        out_ready = 1'b0;
        checkOutput("drain_done", {31'd0, busy}, 32'd0);
    endtask

    // Full message -> start -> done -> eight hash words, checking every step.
    task automatic runHash(input logic [31:0] hashBase, input bit pokeDone, input bit stall);
        int wrBase    = wrAddr.size();
        int outBase   = outData.size();
        int startBase = startCyc.size();
        int stallBase = stallAct.size();
        preload(hashBase);
        wrBase = wrAddr.size();
        applyStimulus(pokeDone);
        checkOutput("tmo_cleared", {31'd0, timeout_err}, 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        checkOutput("in_ready_pad", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("in_ready_pad2", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        waitStart();
        checkOutput("mem_own_wait", {31'd0, mem_own}, 32'd0);
        checkWrites(wrBase);
        if (startCyc.size() > startBase && wrAddr.size() >= wrBase + 32)
            checkOutput("start_after_w31", 32'(startCyc[startBase] - wrCyc[wrBase + 31]), 32'd1);
        repeat (10) tick();
        checkOutput("no_early_valid", {31'd0, out_valid}, 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        checkOutput("valid_d1", {31'd0, out_valid}, 32'd0);
        checkOutput("mem_own_rd", {31'd0, mem_own}, 32'd1);
        tick();
        checkOutput("valid_d2", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("valid_d3", {31'd0, out_valid}, 32'd1);
        drainOutput(stall);
        checkOutput("start_pulses", 32'(startCyc.size() - startBase), 32'd1);
        checkOutput("out_count", 32'(outData.size() - outBase), 32'd8);
        if (outData.size() >= outBase + 8) begin
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("out_data[%0d]", i), outData[outBase + i], hashBase + 32'(i));
                checkOutput($sformatf("out_last[%0d]", i), {31'd0, outLast[outBase + i]}, (i == 7) ? 32'd1 : 32'd0);
            end
            checkOutput("busy_after_last", 32'(cyc - outCyc[outBase + 7]), 32'd1);
        end
        if (stall) begin
            checkOutput("stall_seen", (stallAct.size() > stallBase) ? 32'd1 : 32'd0, 32'd1);
            for (int i = stallBase; i < stallAct.size(); i++)
                checkOutput($sformatf("stall_stable[%0d]", i - stallBase), stallAct[i], stallExp[i]);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        checkOutput({tag, "_mem_own"}, {31'd0, mem_own}, 32'd1);
        checkOutput({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        checkOutput({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_write_data, 32'd0);
        checkOutput({tag, "_eng_start"}, {31'd0, eng_start}, 32'd0);
        checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        checkOutput({tag, "_out_data"}, out_data, 32'd0);
        checkOutput({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    endtask

    initial begin
        int outBase;
        int n;
        logic sawValid;

        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        eng_done    = 1'b0;
        pwIdx       = '0;
        preloadReq  = 1'b0;
        preloadBase = '0;

        for (int i = 0; i < 32; i++) begin
            wrVecs[i].addr = 16'(i);
            if (i < 20)       wrVecs[i].data = 32'(i);
            else if (i == 20) wrVecs[i].data = 32'h8000_0000;
            else if (i == 31) wrVecs[i].data = 32'h0000_0280;
            else              wrVecs[i].data = 32'h0;
        end
        padVecs[0] = '{13, 16'd13, 32'h8000_0000};
        padVecs[1] = '{13, 16'd14, 32'h0000_0000};
        padVecs[2] = '{13, 16'd15, 32'h0000_01A0};
        padVecs[3] = '{14, 16'd14, 32'h8000_0000};
        padVecs[4] = '{14, 16'd15, 32'h0000_0000};
        padVecs[5] = '{14, 16'd30, 32'h0000_0000};
        padVecs[6] = '{14, 16'd31, 32'h0000_01C0};
        padVecs[7] = '{20, 16'd20, 32'h8000_0000};
        padVecs[8] = '{20, 16'd25, 32'h0000_0000};
        padVecs[9] = '{20, 16'd31, 32'h0000_0280};

        repeat (3) tick();
        checkResetValues("reset");
        reset_n = 1'b1;
        tick();
        checkOutput("eng_message_addr", {16'd0, eng_message_addr}, 32'h0000);
        checkOutput("eng_output_addr", {16'd0, eng_output_addr}, 32'h0400);

        checkOutput("padded_13", padded_words(13), 32'd16);
        checkOutput("padded_14", padded_words(14), 32'd32);
        checkOutput("padded_20", padded_words(20), 32'd32);
        checkOutput("msg_bits_20", msg_bits(20), 32'd640);
        for (int i = 0; i < 10; i++) begin
            pwIdx = padVecs[i].idx;
            #1;
            checkOutput($sformatf("pad_n%0d_idx%0d", padVecs[i].n, padVecs[i].idx),
                        (padVecs[i].n == 13) ? pw13 : (padVecs[i].n == 14) ? pw14 : pw20,
                        padVecs[i].exp);
        end

        $display("[TB] run 1: full throughput, eng_done poked during load");
        runHash(32'h0000_00A0, 1'b1, 1'b0);

        $display("[TB] run 2: out_ready pattern 1-0-0-1");
        runHash(32'h0000_00B0, 1'b0, 1'b1);

        $display("[TB] run 3: watchdog expiry");
        outBase = outData.size();
        applyStimulus(1'b0);
        waitStart();
        n = 1;
        sawValid = 1'b0;
        while (busy && n < 200) begin
            if (out_valid) sawValid = 1'b1;
            tick();
            if (busy) n++;
        end
        checkOutput("tmo_wait_cycles", 32'(n), 32'(TMO));
        checkOutput("tmo_flag", {31'd0, timeout_err}, 32'd1);
        checkOutput("tmo_idle", {31'd0, busy}, 32'd0);
        checkOutput("tmo_no_valid", {31'd0, sawValid}, 32'd0);
        checkOutput("tmo_no_output", 32'(outData.size() - outBase), 32'd0);
        eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        repeat (3) tick();
        checkOutput("done_in_idle", {31'd0, busy}, 32'd0);
        checkOutput("tmo_sticky", {31'd0, timeout_err}, 32'd1);

        $display("[TB] run 4: message after timeout");
        runHash(32'h0000_00C0, 1'b0, 1'b0);

        $display("[TB] run 5: reset during PAD, then fresh message");
        applyStimulus(1'b0);
        tick();
        tick();
        checkOutput("pad_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkResetValues("midreset");
        tick();
        reset_n = 1'b1;
        tick();
        runHash(32'h0000_00D0, 1'b0, 1'b1);

        checkOutput("lost_writes", 32'(lostWrites), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
